// File: rtl/data_to_axi_packer.sv
// Packs a stream of DATA_WIDTH elements into AXI_WIDTH beats. Each element goes
// into the next lane, and a beat closes when its last lane fills or an element carries last.
module data_to_axi_packer #(
    parameter int DATA_WIDTH   = 64,
    parameter int AXI_WIDTH    = 512,
    parameter int NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_keep,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [AXI_WIDTH-1:0]   out_tdata,
    output logic [AXI_WIDTH/8-1:0] out_tkeep,
    output logic                   out_tlast,
    output logic                   out_tvalid,
    input  logic                   out_tready
);

    localparam int KEEP_PER_LANE = DATA_WIDTH / 8;
    localparam int CNT_WIDTH     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

    if (AXI_WIDTH != NUM_ELEMENTS * DATA_WIDTH) begin : g_bad_width
        $error("data_to_axi_packer: AXI_WIDTH must equal NUM_ELEMENTS*DATA_WIDTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("data_to_axi_packer: DATA_WIDTH must be a multiple of 8");
    end

    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [AXI_WIDTH-1:0]    acc_data_r;
    logic [NUM_ELEMENTS-1:0] acc_keep_r;
    logic                    ov_r;
    logic [AXI_WIDTH-1:0]    tdata_r;
    logic [AXI_WIDTH/8-1:0]  tkeep_r;
    logic                    tlast_r;

    logic                    accept_s;
    logic                    complete_s;
    logic [AXI_WIDTH-1:0]    beat_data_s;
    logic [AXI_WIDTH/8-1:0]  beat_keep_s;

    assign in_ready   = !ov_r || out_tready;
    assign accept_s   = in_valid && in_ready;
    assign complete_s = accept_s && ((cnt_r == CNT_WIDTH'(NUM_ELEMENTS - 1)) || in_last);

    assign out_tdata  = tdata_r;
    assign out_tkeep  = tkeep_r;
    assign out_tlast  = tlast_r;
    assign out_tvalid = ov_r;

    // Completed beat: filled lanes from the accumulator, current element in lane cnt, rest zero
    always_comb begin
        beat_data_s = '0;
        beat_keep_s = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (CNT_WIDTH'(i) < cnt_r) begin
                beat_data_s[i*DATA_WIDTH +: DATA_WIDTH]       = acc_data_r[i*DATA_WIDTH +: DATA_WIDTH];
                beat_keep_s[i*KEEP_PER_LANE +: KEEP_PER_LANE] = {KEEP_PER_LANE{acc_keep_r[i]}};
            end else if (CNT_WIDTH'(i) == cnt_r) begin
                beat_data_s[i*DATA_WIDTH +: DATA_WIDTH]       = in_data;
                beat_keep_s[i*KEEP_PER_LANE +: KEEP_PER_LANE] = {KEEP_PER_LANE{in_keep}};
            end else begin
                beat_data_s[i*DATA_WIDTH +: DATA_WIDTH]       = {DATA_WIDTH{1'b0}};
                beat_keep_s[i*KEEP_PER_LANE +: KEEP_PER_LANE] = {KEEP_PER_LANE{1'b0}};
            end
        end
    end

    // Lane counter and accumulator; stale accumulator data is masked off by cnt at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (accept_s) begin
            if (complete_s) begin
                cnt_r      <= '0;
                acc_keep_r <= '0;
            end else begin
                acc_data_r[cnt_r*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                acc_keep_r[cnt_r]                          <= in_keep;
                cnt_r                                      <= cnt_r + CNT_WIDTH'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output register: a completing element reloads it even while the old beat drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_r    <= 1'b0;
            tdata_r <= '0;
            tkeep_r <= '0;
            tlast_r <= 1'b0;
        end else if (complete_s) begin
            ov_r    <= 1'b1;
            tdata_r <= beat_data_s;
            tkeep_r <= beat_keep_s;
            tlast_r <= in_last;
        end else if (ov_r && out_tready) begin
            ov_r <= 1'b0;
        end else begin
            ov_r <= ov_r;
        end
    end

endmodule

// File: tb/tb_data_to_axi_packer.sv
// Directed self-checking bench for data_to_axi_packer (8x64 -> 512 and 1x512 -> 512).
module tb_data_to_axi_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  in_data;
    logic         in_keep, in_last, in_valid, in_ready;
    logic [511:0] out_tdata;
    logic [63:0]  out_tkeep;
    logic         out_tlast, out_tvalid, out_tready;

    logic [511:0] s_in_data;
    logic         s_in_keep, s_in_last, s_in_valid, s_in_ready;
    logic [511:0] s_out_tdata;
    logic [63:0]  s_out_tkeep;
    logic         s_out_tlast, s_out_tvalid, s_out_tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_to_axi_packer #(.DATA_WIDTH(64), .AXI_WIDTH(512)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready)
    );

    data_to_axi_packer #(.DATA_WIDTH(512), .AXI_WIDTH(512), .NUM_ELEMENTS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(s_in_data), .in_keep(s_in_keep), .in_last(s_in_last),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_tdata(s_out_tdata), .out_tkeep(s_out_tkeep), .out_tlast(s_out_tlast),
        .out_tvalid(s_out_tvalid), .out_tready(s_out_tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = 64'd0; in_keep = 1'b0; in_last = 1'b0; out_tready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 512'd0; s_in_keep = 1'b0; s_in_last = 1'b0; s_out_tready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", out_tvalid); end
        checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", out_tlast); end
        checks++; if (out_tdata !== 512'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", out_tdata); end
        checks++; if (out_tkeep !== 64'd0) begin errors++; $display("FAIL reset_tkeep got %h want 0", out_tkeep); end
        checks++; if (s_out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_n1 got %b want 0", s_out_tvalid); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_n1 got %b want 1", s_in_ready); end
    endtask

    task automatic test_full_beats();
        logic [511:0] exp0, exp1;
        for (int k = 0; k < 8; k++) begin
            exp0[k*64 +: 64] = 64'(k);
            exp1[k*64 +: 64] = 64'(k + 8);
        end
        out_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_keep = 1'b1; in_last = (i == 15);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready elem %0d got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_tvalid !== ((i == 7) || (i == 15))) begin
                errors++; $display("FAIL full_tvalid elem %0d got %b want %b", i, out_tvalid, ((i == 7) || (i == 15)));
            end
            if (i == 7) begin
                checks++; if (out_tdata !== exp0) begin errors++; $display("FAIL full_beat0_data got %h want %h", out_tdata, exp0); end
                checks++; if (out_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL full_beat0_keep got %h want all ones", out_tkeep); end
                checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL full_beat0_last got %b want 0", out_tlast); end
            end else if (i == 15) begin
                checks++; if (out_tdata !== exp1) begin errors++; $display("FAIL full_beat1_data got %h want %h", out_tdata, exp1); end
                checks++; if (out_tlast !== 1'b1) begin errors++; $display("FAIL full_beat1_last got %b want 1", out_tlast); end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL full_drain_tvalid got %b want 0", out_tvalid); end
    endtask

    task automatic test_partial();
        logic [63:0] vals [3];
        vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
        out_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i]; in_keep = 1'b1; in_last = (i == 2);
            tick();
            checks++; if (out_tvalid !== (i == 2)) begin errors++; $display("FAIL partial_tvalid elem %0d got %b want %b", i, out_tvalid, (i == 2)); end
        end
        checks++; if (out_tkeep !== 64'h0000_0000_00FF_FFFF) begin errors++; $display("FAIL partial_keep got %h want 00000000_00ffffff", out_tkeep); end
        checks++; if (out_tdata !== {320'd0, 64'hC, 64'hB, 64'hA}) begin errors++; $display("FAIL partial_data got %h", out_tdata); end
        checks++; if (out_tlast !== 1'b1) begin errors++; $display("FAIL partial_last got %b want 1", out_tlast); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
    endtask

    task automatic test_keep_zero();
        logic [511:0] expd;
        for (int k = 0; k < 8; k++) expd[k*64 +: 64] = 64'(100 + k);
        out_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'(100 + i); in_keep = (i != 5); in_last = 1'b0;
            tick();
        end
        checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL keep0_tvalid got %b want 1", out_tvalid); end
        checks++; if (out_tkeep !== 64'hFFFF_00FF_FFFF_FFFF) begin errors++; $display("FAIL keep0_keep got %h want ffff00ff_ffffffff", out_tkeep); end
        checks++; if (out_tdata !== expd) begin errors++; $display("FAIL keep0_data got %h want %h", out_tdata, expd); end
        checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL keep0_last got %b want 0", out_tlast); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [511:0] exp_a, exp_b;
        for (int k = 0; k < 8; k++) begin
            exp_a[k*64 +: 64] = 64'(32'h200 + k);
            exp_b[k*64 +: 64] = 64'(32'h300 + k);
        end
        out_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'(32'h200 + i); in_keep = 1'b1; in_last = 1'b0;
            tick();
        end
        checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_rise got %b want 1", out_tvalid); end
        in_data = 64'h300;
        for (int c = 0; c < 5; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
            checks++; if (out_tdata !== exp_a || out_tvalid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cycle %0d got %h valid %b", c, out_tdata, out_tvalid);
            end
            tick();
        end
        out_tready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain_tvalid got %b want 0", out_tvalid); end
        for (int i = 1; i < 8; i++) begin
            in_data = 64'(32'h300 + i); in_last = (i == 7);
            tick();
        end
        checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL bp_beat2_tvalid got %b want 1", out_tvalid); end
        checks++; if (out_tdata !== exp_b) begin errors++; $display("FAIL bp_beat2_data got %h want %h", out_tdata, exp_b); end
        checks++; if (out_tlast !== 1'b1) begin errors++; $display("FAIL bp_beat2_last got %b want 1", out_tlast); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [511:0] expd;
        for (int k = 0; k < 8; k++) expd[k*64 +: 64] = 64'(32'h400 + k);
        out_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'(32'h500 + i); in_keep = 1'b1; in_last = 1'b0;
            tick();
        end
        checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", out_tvalid); end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", out_tvalid); end
        checks++; if (out_tdata !== 512'd0) begin errors++; $display("FAIL rstmid_tdata got %h want 0", out_tdata); end
        #2 rst = 1'b0;
        tick();
        out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 64'(32'h600 + i);
            tick();
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'(32'h400 + i); in_last = 1'b0;
            tick();
            checks++; if (out_tvalid !== (i == 7)) begin errors++; $display("FAIL rstmid_tvalid elem %0d got %b want %b", i, out_tvalid, (i == 7)); end
        end
        checks++; if (out_tdata !== expd) begin errors++; $display("FAIL rstmid_data got %h want %h", out_tdata, expd); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        s_out_tready = 1'b1;
        s_in_valid = 1'b1; s_in_data = {64{8'h55}}; s_in_keep = 1'b1; s_in_last = 1'b1;
        tick();
        checks++; if (s_out_tvalid !== 1'b1) begin errors++; $display("FAIL n1_tvalid got %b want 1", s_out_tvalid); end
        checks++; if (s_out_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL n1_keep1 got %h want all ones", s_out_tkeep); end
        checks++; if (s_out_tlast !== 1'b1) begin errors++; $display("FAIL n1_last got %b want 1", s_out_tlast); end
        checks++; if (s_out_tdata !== {64{8'h55}}) begin errors++; $display("FAIL n1_data got %h", s_out_tdata); end
        s_in_data = {64{8'hA3}}; s_in_keep = 1'b0; s_in_last = 1'b0;
        tick();
        checks++; if (s_out_tvalid !== 1'b1) begin errors++; $display("FAIL n1_b2b_tvalid got %b want 1", s_out_tvalid); end
        checks++; if (s_out_tkeep !== 64'd0) begin errors++; $display("FAIL n1_keep0 got %h want 0", s_out_tkeep); end
        checks++; if (s_out_tdata !== {64{8'hA3}}) begin errors++; $display("FAIL n1_data2 got %h", s_out_tdata); end
        checks++; if (s_out_tlast !== 1'b0) begin errors++; $display("FAIL n1_last2 got %b want 0", s_out_tlast); end
        s_in_valid = 1'b0;
        tick();
        checks++; if (s_out_tvalid !== 1'b0) begin errors++; $display("FAIL n1_drain got %b want 0", s_out_tvalid); end
    endtask

    initial begin
        test_reset();
        test_full_beats();
        test_partial();
        test_keep_zero();
        test_backpressure();
        test_reset_mid();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
